// File: rtl/mips_fetch_pkg.sv
// Shared constants and types for the MIPS instruction fetch unit.
package mips_fetch_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] HALT_ADDR    = 32'h0000_0000;
  localparam logic [31:0] PC_STEP      = 32'd4;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HALTED = 2'd1,
    FAULT  = 2'd2
  } fetch_state_t;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/mips_fetch_unit.sv
// Instruction fetch: PC register, incrementer and delay-slot aware redirect FSM.
//
// state  | meaning
// FETCH  | latching one instruction per enabled edge, PC advances or redirects
// HALTED | jump to HALT_ADDR taken; everything frozen, instr_valid cleared
// FAULT  | misaligned redirect target seen; all outputs frozen until reset
module mips_fetch_unit
  import mips_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  output logic [31:0] instr_address,
  input  logic [31:0] instr_readdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        instr_valid,
  output logic        delay_slot,
  output logic        active,
  output logic        fault
);

  fetch_state_t state;
  logic [31:0]  pc;

  assign instr_address = pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH;
      pc          <= RESET_VECTOR;
      instr_out   <= '0;
      pc_out      <= '0;
      instr_valid <= 1'b0;
      delay_slot  <= 1'b0;
      active      <= 1'b1;
      fault       <= 1'b0;
    end else if (clk_enable) begin
      case (state)
        FETCH: begin
          if (redirect_valid && is_misaligned(redirect_target)) begin
            // Drop the delay slot and expose the bad target for diagnosis.
            state       <= FAULT;
            pc_out      <= redirect_target;
            instr_valid <= 1'b0;
            active      <= 1'b0;
            fault       <= 1'b1;
          end else begin
            instr_out   <= instr_readdata;
            pc_out      <= pc;
            instr_valid <= 1'b1;
            if (redirect_valid) begin
              delay_slot <= 1'b1;
              pc         <= redirect_target;
              if (redirect_target == HALT_ADDR) begin
                state  <= HALTED;
                active <= 1'b0;
              end
            end else begin
              delay_slot <= 1'b0;
              pc         <= pc + PC_STEP;
            end
          end
        end
        HALTED: begin
          instr_valid <= 1'b0;
        end
        FAULT: begin
        end
        default: begin
          state <= FAULT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Table-driven scoreboard bench for mips_fetch_unit.
module tb_mips_fetch_unit;

  localparam logic [31:0] NOP_ADDR = 32'hBFC0_0304;

  typedef struct {
    logic        rst;
    logic        en;
    logic        rv;
    logic [31:0] tgt;
    logic [31:0] addr;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        iv;
    int          ds;   // -1 = not checked
    logic        act;
    logic        flt;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_enable;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic        delay_slot;
  logic        active;
  logic        fault;

  int   errors = 0;
  int   checks = 0;
  int   step_no = 0;
  vec_t tbl[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] ram(input logic [31:0] a);
    if (a == NOP_ADDR) return 32'h0;
    return (a ^ 32'h1234_5678) + 32'd3;
  endfunction

  assign instr_readdata = ram(instr_address);

  mips_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .clk_enable     (clk_enable),
    .instr_address  (instr_address),
    .instr_readdata (instr_readdata),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .instr_out      (instr_out),
    .pc_out         (pc_out),
    .instr_valid    (instr_valid),
    .delay_slot     (delay_slot),
    .active         (active),
    .fault          (fault)
  );

  function automatic vec_t mk(input logic rst, input logic en, input logic rv,
                              input logic [31:0] tgt, input logic [31:0] addr,
                              input logic [31:0] pc, input logic [31:0] instr,
                              input logic iv, input int ds, input logic act,
                              input logic flt);
    vec_t v;
    v.rst = rst; v.en = en; v.rv = rv; v.tgt = tgt;
    v.addr = addr; v.pc = pc; v.instr = instr;
    v.iv = iv; v.ds = ds; v.act = act; v.flt = flt;
    return v;
  endfunction

  function automatic vec_t rst_vec(input logic en, input logic rv, input logic [31:0] tgt);
    return mk(1'b1, en, rv, tgt, 32'hBFC0_0000, 32'h0, 32'h0, 1'b0, 0, 1'b1, 1'b0);
  endfunction

  // Normal fetch step: instruction at pc was latched, next address is addr.
  function automatic vec_t run(input logic rv, input logic [31:0] tgt,
                               input logic [31:0] addr, input logic [31:0] pc, input int ds);
    return mk(1'b0, 1'b1, rv, tgt, addr, pc, ram(pc), 1'b1, ds, 1'b1, 1'b0);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, step_no, got, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    reset           = v.rst;
    clk_enable      = v.en;
    redirect_valid  = v.rv;
    redirect_target = v.tgt;
    sb.push_back(v);
    @(posedge clk);
    #1;
    step_no++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard step %0d: got empty queue expected entry", step_no);
    end else begin
      e = sb.pop_front();
      chk("instr_address", instr_address, e.addr);
      chk("pc_out", pc_out, e.pc);
      chk("instr_out", instr_out, e.instr);
      chk("instr_valid", {31'b0, instr_valid}, {31'b0, e.iv});
      if (e.ds >= 0) chk("delay_slot", {31'b0, delay_slot}, e.ds);
      chk("active", {31'b0, active}, {31'b0, e.act});
      chk("fault", {31'b0, fault}, {31'b0, e.flt});
    end
  endtask

  initial begin
    vec_t fv;
    reset = 1'b1; clk_enable = 1'b0; redirect_valid = 1'b0; redirect_target = '0;

    // Reset and straight-line fetch from the reset vector.
    tbl.push_back(rst_vec(1'b0, 1'b0, 32'h0));
    tbl.push_back(run(1'b0, 32'h0, 32'hBFC0_0004, 32'hBFC0_0000, 0));
    tbl.push_back(run(1'b0, 32'h0, 32'hBFC0_0008, 32'hBFC0_0004, 0));
    tbl.push_back(run(1'b0, 32'h0, 32'hBFC0_000C, 32'hBFC0_0008, 0));
    tbl.push_back(run(1'b0, 32'h0, 32'hBFC0_0010, 32'hBFC0_000C, 0));
    // Redirect with delay slot, then back-to-back redirect.
    tbl.push_back(run(1'b1, 32'hBFC0_0100, 32'hBFC0_0100, 32'hBFC0_0010, 1));
    tbl.push_back(run(1'b1, 32'hBFC0_0200, 32'hBFC0_0200, 32'hBFC0_0100, 1));
    tbl.push_back(run(1'b0, 32'h0, 32'hBFC0_0204, 32'hBFC0_0200, 0));
    // Stall with redirect held: nothing moves until enabled.
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1'b0, 1'b0, 1'b1, 32'hBFC0_0300, 32'hBFC0_0204, 32'hBFC0_0200,
                       ram(32'hBFC0_0200), 1'b1, 0, 1'b1, 1'b0));
    tbl.push_back(run(1'b1, 32'hBFC0_0300, 32'hBFC0_0300, 32'hBFC0_0204, 1));
    tbl.push_back(run(1'b0, 32'h0, 32'hBFC0_0304, 32'hBFC0_0300, 0));
    // jr r0 with nop in the delay slot -> halt.
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 32'h0, 32'h0, NOP_ADDR, 32'h0, 1'b1, 1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 32'hBFC0_0400, 32'h0, NOP_ADDR, 32'h0, 1'b0, -1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, NOP_ADDR, 32'h0, 1'b0, -1, 1'b0, 1'b0));
    // Reset while halted, then restart.
    tbl.push_back(rst_vec(1'b1, 1'b0, 32'h0));
    tbl.push_back(run(1'b0, 32'h0, 32'hBFC0_0004, 32'hBFC0_0000, 0));
    // Reset on the delay-slot edge of a redirect, then restart.
    tbl.push_back(rst_vec(1'b1, 1'b1, 32'hBFC0_0500));
    tbl.push_back(run(1'b0, 32'h0, 32'hBFC0_0004, 32'hBFC0_0000, 0));

    foreach (tbl[i]) apply(tbl[i]);

    // Misaligned redirect -> fault, frozen for 10 cycles regardless of inputs.
    fv = mk(1'b0, 1'b1, 1'b1, 32'hBFC0_0102, 32'hBFC0_0004, 32'hBFC0_0102,
            ram(32'hBFC0_0000), 1'b0, 0, 1'b0, 1'b1);
    apply(fv);
    for (int i = 0; i < 10; i++) begin
      fv.rv  = i[0];
      fv.tgt = 32'hBFC0_0800 + 32'(i * 4);
      apply(fv);
    end
    apply(rst_vec(1'b0, 1'b1, 32'hBFC0_0102));

    // PC wraps from the top of memory to zero without halting.
    apply(run(1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hBFC0_0000, 1));
    apply(run(1'b0, 32'h0, 32'h0, 32'hFFFF_FFFC, 0));
    apply(run(1'b0, 32'h0, 32'h4, 32'h0, 0));

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d left expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
